// File: rtl/compare_reduce_unit.sv
// Multi-lane compare/select unit: per-lane relational ops and min/max with a 1-cycle
// registered result, plus a streaming RMAX/RMIN reduction over in_last-delimited groups.
module compare_reduce_unit #(
    parameter int NUM_LANES     = 4,
    parameter int BIT_WIDTH     = 32,
    parameter int FUNCTION_BITS = 4,
    parameter int IDX_WIDTH     = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_last,
    input  logic [FUNCTION_BITS-1:0]       fn,
    input  logic                           is_signed,
    input  logic [NUM_LANES*BIT_WIDTH-1:0] data_in0,
    input  logic [NUM_LANES*BIT_WIDTH-1:0] data_in1,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_LANES*BIT_WIDTH-1:0] data_out,
    output logic [NUM_LANES*IDX_WIDTH-1:0] idx_out
);

    localparam logic [FUNCTION_BITS-1:0] FN_EQ   = FUNCTION_BITS'(4'h0);
    localparam logic [FUNCTION_BITS-1:0] FN_NE   = FUNCTION_BITS'(4'h1);
    localparam logic [FUNCTION_BITS-1:0] FN_GT   = FUNCTION_BITS'(4'h2);
    localparam logic [FUNCTION_BITS-1:0] FN_GE   = FUNCTION_BITS'(4'h3);
    localparam logic [FUNCTION_BITS-1:0] FN_LT   = FUNCTION_BITS'(4'h4);
    localparam logic [FUNCTION_BITS-1:0] FN_LE   = FUNCTION_BITS'(4'h5);
    localparam logic [FUNCTION_BITS-1:0] FN_MIN  = FUNCTION_BITS'(4'h6);
    localparam logic [FUNCTION_BITS-1:0] FN_MAX  = FUNCTION_BITS'(4'h7);
    localparam logic [FUNCTION_BITS-1:0] FN_RMAX = FUNCTION_BITS'(4'h8);
    localparam logic [FUNCTION_BITS-1:0] FN_RMIN = FUNCTION_BITS'(4'h9);

    typedef enum logic {ST_IDLE, ST_ACCUM} state_t;
    typedef logic [BIT_WIDTH-1:0] lane_t;
    typedef logic [IDX_WIDTH-1:0] idx_t;

    function automatic logic f_less(input lane_t a, input lane_t b, input logic sgn);
        if (sgn) return $signed(a) < $signed(b);
        return a < b;
    endfunction

    state_t r_state;
    state_t w_state_next;
    logic [FUNCTION_BITS-1:0] r_fn;
    logic                     r_signed;
    lane_t                    r_acc [NUM_LANES];
    idx_t                     r_idx [NUM_LANES];
    idx_t                     r_count;
    logic                     r_out_valid;
    logic [NUM_LANES*BIT_WIDTH-1:0] r_data_out;
    logic [NUM_LANES*IDX_WIDTH-1:0] r_idx_out;

    lane_t w_a [NUM_LANES];
    lane_t w_b [NUM_LANES];
    logic  w_lt [NUM_LANES];
    logic  w_eq [NUM_LANES];
    logic  w_a_beats_acc [NUM_LANES];

    logic  w_accept;
    logic  w_is_red_in;
    logic  w_emit;
    logic  w_emit_group;
    logic  w_latch_grp;
    lane_t w_next_acc [NUM_LANES];
    idx_t  w_next_idx [NUM_LANES];
    idx_t  w_next_count;
    logic [NUM_LANES*BIT_WIDTH-1:0] w_elem_data;
    logic [NUM_LANES*BIT_WIDTH-1:0] w_group_data;
    logic [NUM_LANES*IDX_WIDTH-1:0] w_group_idx;
    logic [NUM_LANES*BIT_WIDTH-1:0] w_emit_data;
    logic [NUM_LANES*IDX_WIDTH-1:0] w_emit_idx;

    assign in_ready    = !r_out_valid || out_ready;
    assign w_accept    = in_valid && in_ready;
    assign w_is_red_in = (fn == FN_RMAX) || (fn == FN_RMIN);
    assign out_valid   = r_out_valid;
    assign data_out    = r_data_out;
    assign idx_out     = r_idx_out;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign w_a[g]  = data_in0[g*BIT_WIDTH +: BIT_WIDTH];
        assign w_b[g]  = data_in1[g*BIT_WIDTH +: BIT_WIDTH];
        assign w_lt[g] = f_less(w_a[g], w_b[g], is_signed);
        assign w_eq[g] = (w_a[g] == w_b[g]);
        // Strict improvement only, so ties keep the earliest beat's index.
        assign w_a_beats_acc[g] = (r_fn == FN_RMAX) ? f_less(r_acc[g], w_a[g], r_signed)
                                                    : f_less(w_a[g], r_acc[g], r_signed);
    end

    // NOTE: every combinational output gets a default before the case; a missed branch
    // would otherwise infer a latch.
    always_comb begin
        w_elem_data = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            case (fn)
                FN_EQ:   w_elem_data[i*BIT_WIDTH +: BIT_WIDTH] = BIT_WIDTH'(w_eq[i]);
                FN_NE:   w_elem_data[i*BIT_WIDTH +: BIT_WIDTH] = BIT_WIDTH'(!w_eq[i]);
                FN_GT:   w_elem_data[i*BIT_WIDTH +: BIT_WIDTH] = BIT_WIDTH'(!w_lt[i] && !w_eq[i]);
                FN_GE:   w_elem_data[i*BIT_WIDTH +: BIT_WIDTH] = BIT_WIDTH'(!w_lt[i]);
                FN_LT:   w_elem_data[i*BIT_WIDTH +: BIT_WIDTH] = BIT_WIDTH'(w_lt[i]);
                FN_LE:   w_elem_data[i*BIT_WIDTH +: BIT_WIDTH] = BIT_WIDTH'(w_lt[i] || w_eq[i]);
                FN_MIN:  w_elem_data[i*BIT_WIDTH +: BIT_WIDTH] = (w_lt[i] || w_eq[i]) ? w_a[i] : w_b[i];
                FN_MAX:  w_elem_data[i*BIT_WIDTH +: BIT_WIDTH] = w_lt[i] ? w_b[i] : w_a[i];
                default: w_elem_data[i*BIT_WIDTH +: BIT_WIDTH] = '0;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_emit       = 1'b0;
        w_emit_group = 1'b0;
        w_latch_grp  = 1'b0;
        w_next_acc   = r_acc;
        w_next_idx   = r_idx;
        w_next_count = r_count;
        if (w_accept) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_is_red_in) begin
                        w_latch_grp  = 1'b1;
                        w_next_count = IDX_WIDTH'(1);
                        for (int i = 0; i < NUM_LANES; i++) begin
                            w_next_acc[i] = w_a[i];
                            w_next_idx[i] = '0;
                        end
                        if (in_last) begin
                            w_emit       = 1'b1;
                            w_emit_group = 1'b1;
                        end else begin
                            w_state_next = ST_ACCUM;
                        end
                    end else begin
                        w_emit = 1'b1;
                    end
                end
                ST_ACCUM: begin
                    for (int i = 0; i < NUM_LANES; i++) begin
                        if (w_a_beats_acc[i]) begin
                            w_next_acc[i] = w_a[i];
                            w_next_idx[i] = r_count;
                        end
                    end
                    w_next_count = (r_count == '1) ? r_count : r_count + IDX_WIDTH'(1);
                    if (in_last) begin
                        w_emit       = 1'b1;
                        w_emit_group = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_group_data = '0;
        w_group_idx  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_group_data[i*BIT_WIDTH +: BIT_WIDTH] = w_next_acc[i];
            w_group_idx[i*IDX_WIDTH +: IDX_WIDTH]  = w_next_idx[i];
        end
    end

    assign w_emit_data = w_emit_group ? w_group_data : w_elem_data;
    assign w_emit_idx  = w_emit_group ? w_group_idx  : '0;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_fn        <= '0;
            r_signed    <= 1'b0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_data_out  <= '0;
            r_idx_out   <= '0;
            // NOTE: accumulator arrays are small flops, not RAM, so they reset to a known zero.
            for (int i = 0; i < NUM_LANES; i++) begin
                r_acc[i] <= '0;
                r_idx[i] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            r_count <= w_next_count;
            for (int i = 0; i < NUM_LANES; i++) begin
                r_acc[i] <= w_next_acc[i];
                r_idx[i] <= w_next_idx[i];
            end
            if (w_latch_grp) begin
                r_fn     <= fn;
                r_signed <= is_signed;
            end
            if (w_emit) begin
                r_out_valid <= 1'b1;
                r_data_out  <= w_emit_data;
                r_idx_out   <= w_emit_idx;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_compare_reduce_unit.sv
// Bench for compare_reduce_unit: directed scenarios plus randomized traffic, all results
// scored against an arithmetic reference model that queues expected outputs in order.
module tb_compare_reduce_unit;

    localparam int NL = 4;
    localparam int BW = 32;
    localparam int FB = 4;
    localparam int IW = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [FB-1:0]     fn;
    logic              is_signed;
    logic [NL*BW-1:0]  data_in0;
    logic [NL*BW-1:0]  data_in1;
    logic              out_valid;
    logic              out_ready;
    logic [NL*BW-1:0]  data_out;
    logic [NL*IW-1:0]  idx_out;

    compare_reduce_unit #(
        .NUM_LANES(NL), .BIT_WIDTH(BW), .FUNCTION_BITS(FB), .IDX_WIDTH(IW)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .fn(fn), .is_signed(is_signed),
        .data_in0(data_in0), .data_in1(data_in1),
        .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .idx_out(idx_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [NL*BW-1:0] d;
        logic [NL*IW-1:0] x;
    } exp_t;

    exp_t        exp_q[$];
    bit          m_busy = 0;
    logic [3:0]  m_fn = 0;
    bit          m_sgn = 0;
    logic [31:0] m_acc [NL];
    int          m_idx [NL];
    int          m_count = 0;

    function automatic longint val(input logic [31:0] x, input bit sgn);
        if (sgn) return longint'($signed(x));
        return longint'({32'd0, x});
    endfunction

    function automatic logic [31:0] ref_elem(input logic [3:0] f, input bit sgn,
                                             input logic [31:0] a, input logic [31:0] b);
        longint va = val(a, sgn);
        longint vb = val(b, sgn);
        case (f)
            4'h0: return 32'(va == vb);
            4'h1: return 32'(va != vb);
            4'h2: return 32'(va > vb);
            4'h3: return 32'(va >= vb);
            4'h4: return 32'(va < vb);
            4'h5: return 32'(va <= vb);
            4'h6: return (va <= vb) ? a : b;
            4'h7: return (va >= vb) ? a : b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic push_group();
        exp_t e;
        e.d = '0;
        e.x = '0;
        for (int i = 0; i < NL; i++) begin
            e.d[i*BW +: BW] = m_acc[i];
            e.x[i*IW +: IW] = 16'(m_idx[i]);
        end
        exp_q.push_back(e);
    endtask

    task automatic ref_accept(input logic [3:0] f, input bit sgn, input bit last,
                              input logic [NL*BW-1:0] a, input logic [NL*BW-1:0] b);
        exp_t e;
        logic [31:0] la;
        bit better;
        if (!m_busy) begin
            if (f == 4'h8 || f == 4'h9) begin
                m_fn = f;
                m_sgn = sgn;
                m_count = 1;
                for (int i = 0; i < NL; i++) begin
                    m_acc[i] = a[i*BW +: BW];
                    m_idx[i] = 0;
                end
                if (last) push_group();
                else m_busy = 1;
            end else begin
                e.d = '0;
                e.x = '0;
                for (int i = 0; i < NL; i++)
                    e.d[i*BW +: BW] = ref_elem(f, sgn, a[i*BW +: BW], b[i*BW +: BW]);
                exp_q.push_back(e);
            end
        end else begin
            for (int i = 0; i < NL; i++) begin
                la = a[i*BW +: BW];
                if (m_fn == 4'h8) better = val(la, m_sgn) > val(m_acc[i], m_sgn);
                else              better = val(la, m_sgn) < val(m_acc[i], m_sgn);
                if (better) begin
                    m_acc[i] = la;
                    m_idx[i] = m_count;
                end
            end
            if (m_count < 65535) m_count++;
            if (last) begin
                push_group();
                m_busy = 0;
            end
        end
    endtask

    // ---------------- monitor (samples on negedge) ----------------
    bit               prev_stall = 0;
    logic [NL*BW-1:0] prev_data;
    logic [NL*IW-1:0] prev_idx;
    exp_t             e_mon;

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            m_busy = 0;
            prev_stall = 0;
        end else begin
            check("in_ready", in_ready, !(out_valid && !out_ready));
            if (prev_stall) begin
                check("stall_valid", out_valid, 1'b1);
                check("stall_data", data_out, prev_data);
                check("stall_idx", idx_out, prev_idx);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = data_out;
            prev_idx   = idx_out;
            if (out_valid && out_ready) begin
                check("result_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    e_mon = exp_q.pop_front();
                    check("model_data", data_out, e_mon.d);
                    check("model_idx", idx_out, e_mon.x);
                end
            end
            if (in_valid && in_ready)
                ref_accept(fn, is_signed, in_last, data_in0, data_in1);
        end
    end

    // ---------------- out_ready driver ----------------
    int rdy_mode = 0;
    int cyc = 0;
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                2: out_ready = 1'($urandom % 2);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    function automatic logic [127:0] pack4(input logic [31:0] l0, input logic [31:0] l1,
                                           input logic [31:0] l2, input logic [31:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [31:0] rand_lane();
        case ($urandom % 4)
            0: return 32'($urandom % 4);
            1: return 32'hFFFF_FFFF - 32'($urandom % 4);
            2: return 32'h7FFF_FFFE + 32'($urandom % 4);
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [NL*BW-1:0] rand_vec();
        logic [NL*BW-1:0] v;
        for (int i = 0; i < NL; i++) v[i*BW +: BW] = rand_lane();
        return v;
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] f, input bit sgn, input bit last,
                        input logic [NL*BW-1:0] a, input logic [NL*BW-1:0] b);
        bit ok;
        int budget;
        fn = f; is_signed = sgn; in_last = last; data_in0 = a; data_in1 = b;
        in_valid = 1'b1;
        ok = 0;
        budget = 0;
        while (!ok && budget < 200) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            budget++;
        end
        in_valid = 1'b0;
        check("send_accepted", ok, 1'b1);
    endtask

    task automatic expect_out(input string tag, input logic [127:0] d, input logic [127:0] dmask,
                              input logic [63:0] x, input logic [63:0] xmask);
        @(negedge clk);
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_data"}, data_out & dmask, d & dmask);
        check({tag, "_idx"}, idx_out & xmask, x & xmask);
        sync();
    endtask

    task automatic expect_idle(input string tag);
        @(negedge clk);
        check(tag, out_valid, 1'b0);
        sync();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sync();
        reset = 1'b0;
    endtask

    logic [31:0] exp33 [8] = '{32'd1, 32'd0, 32'd0, 32'd1, 32'd0, 32'd1, 32'd3, 32'd3};
    logic [31:0] exp29 [8] = '{32'd0, 32'd1, 32'd0, 32'd0, 32'd1, 32'd1, 32'd2, 32'd9};
    int          t3_vals [4] = '{4, 9, 9, 2};
    int          t5_vals [3] = '{1, 5, 3};
    int          t6_vals [3] = '{7, 3, 3};
    localparam logic [127:0] LANE0_D = 128'hFFFF_FFFF;
    localparam logic [63:0]  LANE0_X = 64'hFFFF;

    initial begin
        logic [NL*BW-1:0] v;
        logic [NL*BW-1:0] a1;
        logic [NL*BW-1:0] b1;
        bit last;
        logic [3:0] f;
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; fn = '0; is_signed = 1'b0;
        data_in0 = '0; data_in1 = '0;

        // Reset values, observed during and after reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_data_out", data_out, '0);
        check("rst_idx_out", idx_out, '0);
        sync();
        reset = 1'b0;
        expect_idle("rst_release_idle");

        // 1. Unsigned vs signed greater-than, 1-cycle latency
        a1 = pack4(32'hFFFF_FFFF, 5, 7, 0);
        b1 = pack4(1, 5, 3, 0);
        send(4'h2, 1'b0, 1'b0, a1, b1);
        expect_out("t1_unsigned", pack4(1, 0, 1, 0), '1, '0, '1);
        send(4'h2, 1'b1, 1'b0, a1, b1);
        expect_out("t1_signed", pack4(0, 0, 1, 0), '1, '0, '1);

        // 2. Full elementwise sweep plus an undefined code
        for (int k = 0; k < 8; k++) begin
            send(4'(k), 1'b0, 1'b0, {4{32'd3}}, {4{32'd3}});
            expect_out($sformatf("t2_eq_fn%0d", k), {4{exp33[k]}}, '1, '0, '1);
            send(4'(k), 1'b0, 1'b0, {4{32'd2}}, {4{32'd9}});
            expect_out($sformatf("t2_ne_fn%0d", k), {4{exp29[k]}}, '1, '0, '1);
        end
        send(4'hF, 1'b0, 1'b0, rand_vec(), rand_vec());
        expect_out("t2_undef", '0, '1, '0, '1);

        // 3. Four-beat RMAX and RMIN groups, lane 0 = 4,9,9,2
        for (int b = 0; b < 4; b++) begin
            v = rand_vec();
            v[31:0] = 32'(t3_vals[b]);
            send(4'h8, 1'b0, b == 3, v, rand_vec());
            if (b < 3) expect_idle("t3_rmax_nolast");
            else expect_out("t3_rmax", 128'd9, LANE0_D, 64'd1, LANE0_X);
        end
        for (int b = 0; b < 4; b++) begin
            v = rand_vec();
            v[31:0] = 32'(t3_vals[b]);
            send(4'h9, 1'b0, b == 3, v, rand_vec());
            if (b < 3) expect_idle("t3_rmin_nolast");
            else expect_out("t3_rmin", 128'd2, LANE0_D, 64'd3, LANE0_X);
        end

        // 4. Backpressure with out_ready pattern 1,0,0,1
        rdy_mode = 1;
        repeat (8) send(4'($urandom % 8), 1'($urandom % 2), 1'b0, rand_vec(), rand_vec());
        rdy_mode = 0;
        repeat (6) sync();
        check("t4_drained", exp_q.size(), 0);

        // 5. fn change mid-group is ignored; single-beat group
        for (int b = 0; b < 3; b++) begin
            v = rand_vec();
            v[31:0] = 32'(t5_vals[b]);
            send((b == 1) ? 4'h0 : 4'h8, 1'b0, b == 2, v, rand_vec());
        end
        expect_out("t5_fnchange", 128'd5, LANE0_D, 64'd1, LANE0_X);
        v = rand_vec();
        send(4'h9, 1'($urandom % 2), 1'b1, v, rand_vec());
        expect_out("t5_single", v, '1, '0, '1);

        // 6. Reset inside a group, then a fresh 3-beat RMIN group
        send(4'h8, 1'b0, 1'b0, pack4(100, 1, 2, 3), rand_vec());
        send(4'h8, 1'b0, 1'b0, pack4(200, 1, 2, 3), rand_vec());
        do_reset();
        expect_idle("t6_no_partial_a");
        expect_idle("t6_no_partial_b");
        for (int b = 0; b < 3; b++) begin
            v = rand_vec();
            v[31:0] = 32'(t6_vals[b]);
            send(4'h9, 1'b0, b == 2, v, rand_vec());
        end
        expect_out("t6_fresh", 128'd3, LANE0_D, 64'd1, LANE0_X);

        // Reset while a result is stalled drops it
        rdy_mode = 3;
        sync();
        sync();
        send(4'h7, 1'b0, 1'b0, rand_vec(), rand_vec());
        @(negedge clk);
        check("rst_stall_valid", out_valid, 1'b1);
        sync();
        do_reset();
        rdy_mode = 0;
        expect_idle("rst_stall_dropped");

        // Randomized traffic with random backpressure and idle gaps
        rdy_mode = 2;
        for (int n = 0; n < 300; n++) begin
            if ($urandom % 10 < 4) f = ($urandom % 2 == 0) ? 4'h8 : 4'h9;
            else f = 4'($urandom % 16);
            last = ($urandom % 3 == 0);
            if ($urandom % 4 == 0) sync();
            send(f, 1'($urandom % 2), last, rand_vec(), rand_vec());
        end
        send(4'h8, 1'b0, 1'b1, rand_vec(), rand_vec());
        rdy_mode = 0;
        for (int w = 0; w < 50 && (exp_q.size() != 0 || out_valid); w++) sync();
        check("final_drained", exp_q.size(), 0);
        check("final_idle", out_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before the end of stimulus");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/compare_reduce_unit.md
Name: compare_reduce_unit

Overview:
- Multi-lane, pipelined comparison/selection unit for the SIMD datapath.
- Runs per-lane relational ops (signed or unsigned) and elementwise min/max on packed operand vectors.
- Also runs a streaming reduction (running max/min plus beat index) over multi-beat groups delimited by in_last.
- Valid/ready on both sides; sits between the operand fetch stage and the result writeback buffer.

Parameters:
NUM_LANES, 4, number of independent comparison lanes
BIT_WIDTH, 32, bits per lane operand/result
FUNCTION_BITS, 4, width of fn
IDX_WIDTH, 16, width of per-lane reduction index

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  input beat valid
in_ready  output  1  unit accepts beat this cycle
in_last  input  1  final beat of a reduction group (ignored for elementwise fn)
fn  input  FUNCTION_BITS  operation select, sampled on accepted beat
is_signed  input  1  1 = two's-complement compare, 0 = unsigned; sampled like fn
data_in0  input  NUM_LANES*BIT_WIDTH  operand A, lane i at [i*BIT_WIDTH +: BIT_WIDTH]
data_in1  input  NUM_LANES*BIT_WIDTH  operand B, same packing
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
data_out  output  NUM_LANES*BIT_WIDTH  per-lane result
idx_out  output  NUM_LANES*IDX_WIDTH  per-lane reduction index (0 for elementwise)

Behaviour:
- Clock and reset: single clock clk. reset is synchronous, active-high.
- Reset values: out_valid=0, data_out=0, idx_out=0, accumulators=0, beat counter=0, state IDLE.
- A beat is accepted when in_valid && in_ready. in_ready = !out_valid || out_ready (combinational), so it is 1 during and after reset.
- A result is transferred when out_valid && out_ready. data_out/idx_out hold stable while out_valid && !out_ready.
- fn encodings, per lane, with A = data_in0 lane and B = data_in1 lane:
  - Relational, result 1 or 0 zero-extended to BIT_WIDTH: 0000 A==B; 0001 A!=B; 0010 A>B; 0011 A>=B; 0100 A<B; 0101 A<=B.
  - Elementwise select: 0110 min(A,B); 0111 max(A,B). On tie, output A.
  - Reductions over A only (data_in1 ignored): 1000 RMAX; 1001 RMIN.
  - Any other code: data_out=0, idx_out=0, and a result is still produced.
- Elementwise fn (0000-0111 and undefined codes):
  - Accepted beat → out_valid=1 on the next edge, data_out registered. Latency 1 cycle.
  - One result per beat; full throughput when out_ready=1. in_last is ignored.
- Reduction state machine (IDLE, ACCUM):
  - IDLE, accepted beat with fn in {1000,1001}:
    - Latch fn and is_signed for the group.
    - acc[i] = A[i], idx[i] = 0, count = 1.
    - If in_last, emit immediately (single-beat group) and stay IDLE; else go to ACCUM.
  - ACCUM, each accepted beat:
    - fn and is_signed inputs are ignored; the latched values are used.
    - Update acc[i] only if A[i] is strictly greater (RMAX) or strictly less (RMIN). On update, idx[i] = count. Ties keep the earliest index.
    - count increments and saturates at 2^IDX_WIDTH-1.
    - Non-last beats produce no output.
    - in_last beat: the final acc/idx (including this beat) are registered to data_out/idx_out, out_valid=1 on the next edge, return to IDLE.
  - Non-last beats are still gated by in_ready, so a stalled output backpressures the group.
- Signed mode: lanes are compared as two's complement, e.g. 0xFFFFFFFF < 0x00000001. Unsigned mode: 0xFFFFFFFF > 0x00000001.
- Lanes are fully independent; no carry or interaction between lanes.
- Simultaneous output transfer and input accept in the same cycle: the new result replaces the old one; no bubble.
- Reset mid-group: the group is discarded, state returns to IDLE, and no partial result is emitted.
- Reset while out_valid=1: the result is dropped and out_valid=0 next cycle.

Test Plan:
1. Unsigned vs signed: NUM_LANES=4, A={0xFFFFFFFF,5,7,0}, B={1,5,3,0}, fn=0010. is_signed=0 → {1,0,1,0}; is_signed=1 → {0,0,1,0}. Both 1 cycle after accept.
2. Full op sweep: every fn 0000-0111 on A=3, B=3 and on A=2, B=9 (unsigned). Check all expected values, including min/max tie output = A. fn=1111 → data_out=0, out_valid=1.
3. Reduction: RMAX, 4 beats, lane0 A = 4, 9, 9, 2, in_last on beat 4. Expect exactly one result, data_out lane0=9, idx_out lane0=1 (earliest tie). RMIN on the same data → 2, idx 3.
4. Backpressure: stream 8 elementwise beats with out_ready toggling 1,0,0,1,…. No result lost or duplicated, order preserved, data_out stable while stalled, in_ready=0 exactly when out_valid && !out_ready.
5. Group control: fn changed to 0000 on beat 2 of an RMAX group → ignored, group completes as RMAX. Single-beat group (in_last on first beat) → idx 0, data = A.
6. Reset in ACCUM after 2 beats → no output. The next 3-beat RMIN group starts fresh with idx counted from 0.
